// File: rtl/decode_issue_unit.sv
// RV32I decode/issue stage: register file with write-through bypass, load-use
// interlock and a single ID/EX pipeline register with hold and flush.
module decode_issue_unit #(
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int RF_INIT = 0,
   localparam int AW     = $clog2(NREG)
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            ID_Valid,
   output logic            ID_Ready,
   input  logic [31:0]     IR,
   input  logic [XLEN-1:0] PC_ID,
   input  logic            WB_Enable,
   input  logic [AW-1:0]   rd_WB,
   input  logic [XLEN-1:0] Data_WB,
   input  logic            Flush,
   input  logic            EX_Ready,
   output logic            EX_Valid,
   output logic [XLEN-1:0] Operand1_ACU_EX,
   output logic [XLEN-1:0] Operand2_ACU_EX,
   output logic [XLEN-1:0] Operand1_DEU_EX,
   output logic [XLEN-1:0] Operand2_DEU_EX,
   output logic [4:0]      Alu_Cntrl_EX,
   output logic [2:0]      Func3_EX,
   output logic [6:0]      Imm_Format_EX,
   output logic [AW-1:0]   rd_EX,
   output logic [AW-1:0]   rs1_EX,
   output logic [AW-1:0]   rs2_EX,
   output logic            Rs1_Valid_EX,
   output logic            Rs2_Valid_EX,
   output logic            Write_Enable_EX,
   output logic            Illegal_EX,
   output logic [15:0]     Stall_Count
);

   typedef struct packed {
      logic [XLEN-1:0] a1, a2, d1, d2;
      logic [4:0]      alu;
      logic [2:0]      f3;
      logic [6:0]      fmt;
      logic [AW-1:0]   rd, rs1, rs2;
      logic            v1, v2, we, ill;
   } idex_t;

   logic [XLEN-1:0] rf [NREG];
   idex_t           dec, q;
   logic            ex_valid, rs1_u, rs2_u, hazard, accept;
   logic [AW-1:0]   rs1_a, rs2_a, rd_a;
   logic [XLEN-1:0] r1, r2, imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [6:0]      opc, f7;
   logic [2:0]      f3;
   logic            wb_hit;

   assign opc   = IR[6:0];
   assign f3    = IR[14:12];
   assign f7    = IR[31:25];
   assign rs1_a = AW'(IR[19:15]);
   assign rs2_a = AW'(IR[24:20]);
   assign rd_a  = AW'(IR[11:7]);

   assign imm_i = XLEN'($signed(IR[31:20]));
   assign imm_s = XLEN'($signed({IR[31:25], IR[11:7]}));
   assign imm_b = XLEN'($signed({IR[31], IR[7], IR[30:25], IR[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({IR[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({IR[31], IR[19:12], IR[20], IR[30:21], 1'b0}));

   // x0 reads zero; a same-cycle write-back to a nonzero register is bypassed
   assign wb_hit = WB_Enable && (rd_WB != '0);
   assign r1 = (rs1_a == '0) ? '0 : (wb_hit && rd_WB == rs1_a) ? Data_WB : rf[rs1_a];
   assign r2 = (rs2_a == '0) ? '0 : (wb_hit && rd_WB == rs2_a) ? Data_WB : rf[rs2_a];

   // Sources are only routed when used, so unused reads contribute zero
   always_comb begin
      dec   = '0;
      rs1_u = 1'b0;
      rs2_u = 1'b0;
      dec.rd = rd_a;
      dec.f3 = f3;
      case (opc)
         7'b0110011: begin
            dec.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            rs1_u = 1'b1; rs2_u = 1'b1; dec.we = 1'b1;
            dec.alu = {1'b0, f7[5], f3};
            dec.d1 = r1; dec.d2 = r2;
         end
         7'b0010011: begin
            rs1_u = 1'b1; dec.we = 1'b1; dec.d1 = r1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
               dec.ill = !(f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20));
               dec.alu = {1'b0, f7[5], f3};
               dec.d2  = XLEN'(IR[24:20]);
            end else begin
               dec.alu = {2'b00, f3};
               dec.d2  = imm_i;
            end
         end
         7'b0000011: begin
            dec.ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
            rs1_u = 1'b1; dec.we = 1'b1; dec.fmt = 7'b1000000;
            dec.a1 = r1; dec.a2 = imm_i;
         end
         7'b0100011: begin
            dec.ill = (f3 > 3'd2);
            rs1_u = 1'b1; rs2_u = 1'b1; dec.fmt = 7'b0100000;
            dec.a1 = r1; dec.a2 = imm_s; dec.d2 = r2;
         end
         7'b1100011: begin
            dec.ill = (f3 == 3'd2 || f3 == 3'd3);
            rs1_u = 1'b1; rs2_u = 1'b1; dec.fmt = 7'b0010000;
            dec.alu = {2'b10, f3};
            dec.a1 = PC_ID; dec.a2 = imm_b; dec.d1 = r1; dec.d2 = r2;
         end
         7'b0110111: begin
            dec.we = 1'b1; dec.fmt = 7'b0001000; dec.f3 = '0;
            dec.d2 = imm_u;
         end
         7'b0010111: begin
            dec.we = 1'b1; dec.fmt = 7'b0000100; dec.f3 = '0;
            dec.a1 = PC_ID; dec.a2 = imm_u;
         end
         7'b1101111: begin
            dec.we = 1'b1; dec.fmt = 7'b0000010; dec.f3 = '0;
            dec.a1 = PC_ID; dec.a2 = imm_j; dec.d1 = PC_ID; dec.d2 = XLEN'(4);
         end
         7'b1100111: begin
            dec.ill = (f3 != 3'd0);
            rs1_u = 1'b1; dec.we = 1'b1; dec.fmt = 7'b0000001;
            dec.a1 = r1; dec.a2 = imm_i; dec.d1 = PC_ID; dec.d2 = XLEN'(4);
         end
         default: dec.ill = 1'b1;
      endcase
      if (dec.ill) begin
         dec     = '0;
         dec.ill = 1'b1;
         rs1_u   = 1'b0;
         rs2_u   = 1'b0;
      end
      dec.v1  = rs1_u;
      dec.v2  = rs2_u;
      dec.rs1 = rs1_u ? rs1_a : '0;
      dec.rs2 = rs2_u ? rs2_a : '0;
   end

   // Load result is not available until after EX, so the bypass cannot help
   assign hazard = ex_valid && q.fmt[6] && (q.rd != '0) &&
                   ((rs1_u && rs1_a == q.rd) || (rs2_u && rs2_a == q.rd));
   assign ID_Ready = Reset && (!ex_valid || EX_Ready) && !hazard && !Flush;
   assign accept   = ID_Valid && ID_Ready;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         for (int i = 0; i < NREG; i++)
            rf[i] <= (RF_INIT == 1) ? XLEN'(i) : '0;
      end else if (wb_hit) begin
         rf[rd_WB] <= Data_WB;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         q           <= '0;
         ex_valid    <= 1'b0;
         Stall_Count <= '0;
      end else begin
         if (Flush)
            ex_valid <= 1'b0;
         else if (accept) begin
            q        <= dec;
            ex_valid <= 1'b1;
         end else if (EX_Ready)
            ex_valid <= 1'b0;
         if (ID_Valid && hazard && Stall_Count != 16'hFFFF)
            Stall_Count <= Stall_Count + 16'd1;
      end
   end

   assign EX_Valid        = ex_valid;
   assign Operand1_ACU_EX = q.a1;
   assign Operand2_ACU_EX = q.a2;
   assign Operand1_DEU_EX = q.d1;
   assign Operand2_DEU_EX = q.d2;
   assign Alu_Cntrl_EX    = q.alu;
   assign Func3_EX        = q.f3;
   assign Imm_Format_EX   = q.fmt;
   assign rd_EX           = q.rd;
   assign rs1_EX          = q.rs1;
   assign rs2_EX          = q.rs2;
   assign Rs1_Valid_EX    = q.v1 & ex_valid;
   assign Rs2_Valid_EX    = q.v2 & ex_valid;
   assign Write_Enable_EX = q.we & ex_valid;
   assign Illegal_EX      = q.ill & ex_valid;

endmodule
